bit_packer: RTL and testbench
=============================

# bit_packer

Sequential bit-stream writer and packing counterpart to the combinational funnel-shifter bit extractor. It accepts variable-length fields of 0–8 bits and appends each one LSB-first to a 16-bit accumulator. It emits completed bytes over a valid/ready interface, and on an end-of-stream beat it zero-pads the final partial byte. The produced byte stream is exactly what the extractor reads back when its bit offset advances by each field length.

## Interface
Parameters: none; widths are fixed by `bit_packer_pkg`.

Ports:
- `clk`  in  1  — the block's only clock.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — an input field beat is presented.
- `in_ready`  out  1  — the block accepts the beat this cycle.
- `in_data`  in  8  — field bits, LSB-aligned; bits at index ≥ len are ignored.
- `in_len`  in  4  — field length. 0 means no bits. Values 9–15 are clamped to 8.
- `in_last`  in  1  — end of stream; flush after this beat's bits are appended.
- `out_valid`  out  1  — `out_data` holds a completed byte.
- `out_ready`  in  1  — the consumer takes the byte.
- `out_data`  out  8  — equal to `acc[7:0]`.
- `byte_cnt`  out  16  — present only with `BIT_PACKER_CNT_EN`.

## Operation
State:
- `acc[15:0]`
- `cnt[4:0]`, range 0–15
- FSM state, either `FILL` or `DRAIN`

Transfer rules:
- An input beat fires when `in_valid & in_ready`; the output fires when `out_valid & out_ready`.
- On an input fire: `acc |= (in_data & mask(len)) << cnt'`, then `cnt' += len`.
  - `cnt'` and `acc` are the values after any output fire in the same cycle.
- On an output fire: `acc >>= 8` with zero fill, and `cnt -= 8`, or `cnt := 0` when `cnt < 8`.

Control signals:
- `out_valid = (cnt >= 8) | (state == DRAIN & cnt != 0)`.
- `in_ready = (state == FILL) & ((cnt < 8) | (cnt >= 8 & out_ready))`.
  - This path is combinational from `out_ready`, which permits a simultaneous accept and emit.

FSM transitions:
- `FILL` → `DRAIN` on an accepted `in_last` beat.
- `DRAIN` → `FILL` when `cnt` becomes 0, including the cycle immediately after the last beat if that beat left `cnt == 0`.
- In `DRAIN`, a partial byte (`cnt` 1–7) is emitted with its upper bits zero, then `cnt := 0`.

Invariant: `cnt ≤ 15` always, because an accept with `cnt ≥ 8` requires a concurrent emit.

Boundary cases:
- A `len = 0` beat is accepted with no state change, except that `in_last` is honoured.
- If `cnt` is 0 when `in_last` is accepted, no padding byte is produced.
- `rst` at any time, including mid-`DRAIN`, returns the block to its reset state. Partial bits are discarded.

## Timing
Reset values:
- `acc = 0`, `cnt = 0`, state `FILL`.
- `out_valid = 0`, `out_data = 0x00`, `in_ready = 1`, `byte_cnt = 0`.

Latency:
- A byte completed by the beat accepted in cycle t shows `out_valid` in cycle t+1.
- `out_data` stays stable while `out_valid & !out_ready`.

Throughput:
- One byte per cycle with 8-bit fields when `out_ready` is held high.
- Flush costs at most 2 output cycles after the last beat.

## Configuration
`BIT_PACKER_CNT_EN` selects the byte counter:
- Defined: adds the `byte_cnt` output, a 16-bit count of output fires since reset that wraps from 0xFFFF to 0.
- Undefined: the port and the register are both absent. All other behaviour is identical.

## Structure
- `bit_packer_pkg` holds:
  - `state_t` enum (`FILL`, `DRAIN`)
  - `ACC_W = 16`, `FIELD_W = 8`, `LEN_W = 4`
- Sub-module `field_inserter` is combinational. It masks the field to `len` bits and left-shifts it into 16 bits by `cnt`, as a 4-stage mux shifter.

## Test plan
1. Reset: assert `rst` for 2 cycles → `out_valid = 0`, `in_ready = 1`, `out_data = 0x00`; with the macro defined, `byte_cnt = 0`.
2. Accept len 4 / 0x3, then len 4 / 0xA → `out_data = 0xA3` one cycle after the second accept; `cnt` then returns to 0.
3. Accept len 3 / 0x5, then len 8 / 0xFF → out 0xFD. Then a len 0 beat with `in_last` → padded out 0x07, then state `FILL`.
4. Four beats of len 2 / 0xFE → out 0xAA; the masked upper bits are ignored.
5. Backpressure: with `cnt = 12` and `out_ready` low for 5 cycles → `out_data` stable, `in_ready = 0`. Release → byte fires, `cnt = 4`.
6. Simultaneous events: with `cnt = 8` pending and `out_ready = 1`, accept len 8 / 0x5A in the same cycle → next byte is 0x5A. Then assert `rst` mid-`DRAIN` → reset values are restored.

Source files
------------

// File: rtl/bit_packer_pkg.sv
// Shared widths, FSM state type and length clamp for the bit_packer slice.
package bit_packer_pkg;

  localparam int unsigned ACC_W   = 16;
  localparam int unsigned FIELD_W = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_W   = 5;

  typedef enum logic {
    FILL,
    DRAIN
  } state_t;

  // Lengths above a full field behave as a full field.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > 4'd8) ? 4'd8 : len;
  endfunction

endpackage

// File: rtl/field_inserter.sv
// Masks a field to len bits and left-shifts it by shift into the accumulator width.
module field_inserter
  import bit_packer_pkg::*;
(
  input  logic [FIELD_W-1:0] data,
  input  logic [LEN_W-1:0]   len,
  input  logic [3:0]         shift,
  output logic [ACC_W-1:0]   field
);

  logic [FIELD_W-1:0] mask;
  logic [FIELD_W-1:0] masked;
  logic [ACC_W-1:0]   st0, st1, st2, st3;

  always_comb begin
    mask = '0;
    for (int i = 0; i < FIELD_W; i++) begin
      mask[i] = (i < int'(len));
    end
    masked = data & mask;
    // Four binary mux stages: shift by 1, 2, 4, 8.
    st0   = {{(ACC_W-FIELD_W){1'b0}}, masked};
    st1   = shift[0] ? {st0[ACC_W-2:0], 1'b0}  : st0;
    st2   = shift[1] ? {st1[ACC_W-3:0], 2'b0}  : st1;
    st3   = shift[2] ? {st2[ACC_W-5:0], 4'b0}  : st2;
    field = shift[3] ? {st3[ACC_W-9:0], 8'b0}  : st3;
  end

endmodule

// File: rtl/bit_packer.sv
// LSB-first bit-stream packer with zero-padded flush on end of stream.
// Optional byte_cnt output enabled by defining BIT_PACKER_CNT_EN.
module bit_packer
  import bit_packer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FIELD_W-1:0] in_data,
  input  logic [LEN_W-1:0]   in_len,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef BIT_PACKER_CNT_EN
  output logic [15:0]        byte_cnt,
`endif
  output logic [7:0]         out_data
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_shr, field;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_shr;
  logic [LEN_W-1:0]   len_c;
  logic               in_fire, out_fire;

  assign len_c    = clamp_len(in_len);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = acc_q[7:0];

  field_inserter u_field_inserter (
    .data  (in_data),
    .len   (len_c),
    .shift (cnt_shr[3:0]),
    .field (field)
  );

  // Datapath: the output shift happens first, so the new field lands on the post-emit count.
  always_comb begin
    acc_shr = acc_q;
    cnt_shr = cnt_q;
    if (out_fire) begin
      acc_shr = {8'h00, acc_q[ACC_W-1:8]};
      cnt_shr = (cnt_q >= 5'd8) ? cnt_q - 5'd8 : 5'd0;
    end
    acc_d = acc_shr;
    cnt_d = cnt_shr;
    if (in_fire) begin
      acc_d = acc_shr | field;
      cnt_d = cnt_shr + {1'b0, len_c};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (in_fire && in_last) state_d = DRAIN;
      DRAIN:   if (cnt_d == 5'd0) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // in_ready depends combinationally on out_ready so a full byte can drain while a beat lands.
  always_comb begin
    out_valid = (cnt_q >= 5'd8) | ((state_q == DRAIN) & (cnt_q != 5'd0));
    in_ready  = (state_q == FILL) & ((cnt_q < 5'd8) | out_ready);
  end

`ifdef BIT_PACKER_CNT_EN
  logic [15:0] byte_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
    end else if (out_fire) begin
      byte_cnt_q <= byte_cnt_q + 16'd1;
    end
  end

  assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_bit_packer.sv
// Self-checking bench for bit_packer: directed vector table, hand sequences, random vs bit-queue model.
module tb_bit_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic       out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [3:0] in_len;
`ifdef BIT_PACKER_CNT_EN
  logic [15:0] byte_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BIT_PACKER_CNT_EN
    .byte_cnt  (byte_cnt),
`endif
    .out_data  (out_data)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [3:0] len;
    logic       last;
    logic       ordy;
    logic       ov;
    logic       ir;
    logic [7:0] od;
  } vec_t;

  vec_t tbl[15];

  // Reference model: a queue of pending bits plus a drain flag.
  bit mq[$];
  bit m_drain;
  int m_bytes;

  // Present inputs, check outputs before the next edge, then step one cycle.
  task automatic step_chk(input logic v, input logic [7:0] d, input logic [3:0] len,
                          input logic last, input logic ordy, input logic e_ov,
                          input logic e_ir, input logic [7:0] e_od, input string name);
    in_valid = v; in_data = d; in_len = len; in_last = last; out_ready = ordy;
    #2;
    n_vec++;
    if ({out_valid, in_ready, out_data} !== {e_ov, e_ir, e_od}) begin
      n_err++;
      $display("FAIL %s: got ov=%0b ir=%0b od=%02h, want ov=%0b ir=%0b od=%02h",
               name, out_valid, in_ready, out_data, e_ov, e_ir, e_od);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_len = '0; out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_drain = 1'b0;
    m_bytes = 0;
  endtask

  task automatic rand_step(input int idx);
    logic       v, last, ordy, e_ov, e_ir;
    logic [7:0] d, e_od;
    logic [3:0] len;
    int         n;
    v    = ($urandom_range(0, 9) < 7);
    d    = 8'($urandom);
    len  = 4'($urandom_range(0, 15));
    last = ($urandom_range(0, 19) == 0);
    ordy = ($urandom_range(0, 9) < 7);
    in_valid = v; in_data = d; in_len = len; in_last = last; out_ready = ordy;
    #2;
    e_ov = (mq.size() >= 8) || (m_drain && mq.size() > 0);
    e_ir = !m_drain && (mq.size() < 8 || ordy);
    e_od = '0;
    for (int i = 0; i < 8; i++) if (i < mq.size()) e_od[i] = mq[i];
    n_vec++;
    if ({out_valid, in_ready, out_data} !== {e_ov, e_ir, e_od}) begin
      n_err++;
      $display("FAIL rand[%0d]: got ov=%0b ir=%0b od=%02h, want ov=%0b ir=%0b od=%02h",
               idx, out_valid, in_ready, out_data, e_ov, e_ir, e_od);
    end
    @(posedge clk);
    if (e_ov && ordy) begin
      for (int i = 0; i < 8 && mq.size() > 0; i++) void'(mq.pop_front());
      m_bytes++;
    end
    if (e_ir && v) begin
      n = (int'(len) > 8) ? 8 : int'(len);
      for (int i = 0; i < n; i++) mq.push_back(d[i]);
      if (last) m_drain = 1'b1;
    end else if (m_drain && mq.size() == 0) begin
      m_drain = 1'b0;
    end
    #1;
  endtask

  initial begin
    // Fields: v, d, len, last, ordy | expected ov, ir, od
    tbl[0]  = '{1'b1, 8'h03, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[1]  = '{1'b1, 8'h0A, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03};
    tbl[2]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3};
    tbl[3]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 8'h05, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[5]  = '{1'b1, 8'hFF, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05};
    tbl[6]  = '{1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFD};
    tbl[7]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07};
    tbl[8]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[9]  = '{1'b1, 8'hFE, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[10] = '{1'b1, 8'hFE, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02};
    tbl[11] = '{1'b1, 8'hFE, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0A};
    tbl[12] = '{1'b1, 8'hFE, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h2A};
    tbl[13] = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA};
    tbl[14] = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};

    do_reset(2);
`ifdef BIT_PACKER_CNT_EN
    n_vec++;
    if (byte_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_byte_cnt: got %04h, want 0000", byte_cnt);
    end
`endif
    step_chk(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "reset");

    for (int i = 0; i < 15; i++) begin
      step_chk(tbl[i].v, tbl[i].d, tbl[i].len, tbl[i].last, tbl[i].ordy,
               tbl[i].ov, tbl[i].ir, tbl[i].od, $sformatf("table[%0d]", i));
    end

    // Backpressure with 12 bits held.
    step_chk(1'b1, 8'h0C, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "bp_fill0");
    step_chk(1'b1, 8'h3B, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0C, "bp_fill1");
    for (int i = 0; i < 5; i++) begin
      step_chk(1'b1, 8'hFF, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'hBC, $sformatf("bp_hold[%0d]", i));
    end
    step_chk(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hBC, "bp_release");
    step_chk(1'b1, 8'h06, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, "bp_cnt4");

    // Simultaneous accept and emit, then reset while draining.
    step_chk(1'b1, 8'h5A, 4'd8, 1'b0, 1'b1, 1'b1, 1'b1, 8'h63, "simul_emit");
    step_chk(1'b1, 8'h07, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, "simul_next");
    step_chk(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07, "drain_hold");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef BIT_PACKER_CNT_EN
    n_vec++;
    if (byte_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rst_drain_byte_cnt: got %04h, want 0000", byte_cnt);
    end
`endif
    step_chk(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "rst_mid_drain");

    do_reset(1);
    for (int i = 0; i < 3000; i++) rand_step(i);
`ifdef BIT_PACKER_CNT_EN
    n_vec++;
    if (byte_cnt !== 16'(m_bytes)) begin
      n_err++;
      $display("FAIL rand_byte_cnt: got %04h, want %04h", byte_cnt, 16'(m_bytes));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
